// File: rtl/booth_acc_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : booth_acc_stage
// Purpose  : Resolves the Booth/Wallace carry-save pair in two pipelined halves
//            and accumulates signed products into a wide, optionally
//            saturating accumulator, with valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module booth_acc_stage #(
  parameter int ACC_W  = 40,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      sum_i,
  input  logic [31:0]      carry_i,
  input  logic             first_i,
  input  logic             last_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_o,
  output logic             ovf_o,
  output logic [31:0]      prod_o
);

  localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic w_en;
  logic w_accept;
  logic r_out_valid;

  assign w_en     = !(r_out_valid && !out_ready);
  assign w_accept = in_valid && w_en;
  assign in_ready = w_en;

  // S1: low half resolved on accept, high halves and carry-out staged
  logic [16:0] w_lo;
  logic [15:0] r_lo;
  logic        r_c16;
  logic [15:0] r_shi;
  logic [15:0] r_chi;
  logic        r_f1;
  logic        r_l1;
  logic        r_v1;

  assign w_lo = {1'b0, sum_i[15:0]} + {1'b0, carry_i[15:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo  <= '0;
      r_c16 <= 1'b0;
      r_shi <= '0;
      r_chi <= '0;
      r_f1  <= 1'b0;
      r_l1  <= 1'b0;
      r_v1  <= 1'b0;
    end else if (w_en) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_lo  <= w_lo[15:0];
        r_c16 <= w_lo[16];
        r_shi <= sum_i[31:16];
        r_chi <= carry_i[31:16];
        r_f1  <= first_i;
        r_l1  <= last_i;
      end
    end
  end

  // S2: high half completes the product
  logic [15:0] w_hi;
  logic [31:0] r_prod;
  logic        r_f2;
  logic        r_l2;
  logic        r_v2;

  assign w_hi = r_shi + r_chi + {15'd0, r_c16};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod <= '0;
      r_f2   <= 1'b0;
      r_l2   <= 1'b0;
      r_v2   <= 1'b0;
    end else if (w_en) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_prod <= {w_hi, r_lo};
        r_f2   <= r_f1;
        r_l2   <= r_l1;
      end
    end
  end

  assign prod_o = r_prod;

  // S3: one extra bit of headroom exposes signed overflow of the add
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [ACC_W-1:0] w_p;
  logic [ACC_W:0]   w_sum;
  logic             w_of;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_ovf_nxt;

  assign w_p   = {{(ACC_W-32){r_prod[31]}}, r_prod};
  assign w_sum = {r_acc[ACC_W-1], r_acc} + {w_p[ACC_W-1], w_p};
  assign w_of  = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_comb begin
    w_acc_nxt = w_sum[ACC_W-1:0];
    w_ovf_nxt = r_ovf | w_of;
    if (r_f2) begin
      w_acc_nxt = w_p;
      w_ovf_nxt = 1'b0;
    end else if (SAT_EN && w_of) begin
      w_acc_nxt = w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_en && r_v2) begin
      r_acc <= w_acc_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  // Result register: a new result takes priority over the consumer's pop
  logic [ACC_W-1:0] r_acc_out;
  logic             r_ovf_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_acc_out   <= '0;
      r_ovf_out   <= 1'b0;
    end else if (w_en && r_v2 && r_l2) begin
      r_out_valid <= 1'b1;
      r_acc_out   <= w_acc_nxt;
      r_ovf_out   <= w_ovf_nxt;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign acc_o     = r_acc_out;
  assign ovf_o     = r_ovf_out;

endmodule
`default_nettype wire

// File: tb/tb_booth_acc_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_booth_acc_stage
// Purpose  : Directed and randomized checks of booth_acc_stage against a
//            plain-arithmetic accumulation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_acc_stage;

  localparam int     ACC_W = 40;
  localparam longint MAXV  = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint MINV  = -(longint'(1) <<< (ACC_W-1));

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      sum_i = '0;
  logic [31:0]      carry_i = '0;
  logic             first_i = 1'b0;
  logic             last_i = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] acc_o;
  logic             ovf_o;
  logic [31:0]      prod_o;

  always #5 clk = ~clk;

  booth_acc_stage #(.ACC_W(ACC_W), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum_i(sum_i), .carry_i(carry_i), .first_i(first_i), .last_i(last_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_o(acc_o), .ovf_o(ovf_o), .prod_o(prod_o)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: running signed sum with clamping, results queued in order
  logic [40:0]      exp_q[$];
  logic [40:0]      e;
  logic [31:0]      m_s;
  longint           m_acc = 0;
  longint           m_p;
  bit               m_ovf = 1'b0;
  int               n_out = 0;
  logic [ACC_W-1:0] last_acc = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_acc = 0;
      m_ovf = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $error("FAIL extra_result: observed=0x%0h expected=no result", acc_o);
        end else begin
          e = exp_q.pop_front();
          chk("result_acc", 64'(acc_o), 64'(e[39:0]));
          chk("result_ovf", 64'(ovf_o), 64'(e[40]));
          last_acc = acc_o;
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        m_s = sum_i + carry_i;
        m_p = longint'($signed(m_s));
        if (first_i) begin
          m_acc = m_p;
          m_ovf = 1'b0;
        end else begin
          m_acc = m_acc + m_p;
          if (m_acc > MAXV) begin m_acc = MAXV; m_ovf = 1'b1; end
          else if (m_acc < MINV) begin m_acc = MINV; m_ovf = 1'b1; end
        end
        if (last_i) exp_q.push_back({m_ovf, m_acc[39:0]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] s, input logic [31:0] c, input logic f, input logic l);
    in_valid = 1'b1;
    sum_i    = s;
    carry_i  = c;
    first_i  = f;
    last_i   = l;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [31:0] s, input logic [31:0] c, input logic f, input logic l, input bit rnd);
    bit got;
    got = 1'b0;
    put(s, c, f, l);
    for (int i = 0; i < 50 && !got; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_checks++;
      n_err++;
      $error("FAIL send_timeout: observed=no accept expected=accept");
    end
  endtask

  task automatic wait_out(input string tag);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    chk(tag, 64'(out_valid), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    shortint          a, b;
    int               pi;
    logic [31:0]      pv, r;
    longint           ref_sum;
    int               target;

    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_acc", 64'(acc_o), 64'd0);
    chk("rst_ovf", 64'(ovf_o), 64'd0);
    chk("rst_prod", 64'(prod_o), 64'd0);
    #1 rst = 1'b0;
    step();

    // Single product -15, latency check
    put(32'hFFFF_FFF0, 32'h0000_0001, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    chk("single_valid_early", 64'(out_valid), 64'd0);
    step();
    chk("single_prod", 64'(prod_o), 64'hFFFF_FFF1);
    chk("single_valid_k1", 64'(out_valid), 64'd0);
    step();
    chk("single_acc", 64'(acc_o), 64'hFF_FFFF_FFF1);
    chk("single_valid_k2", 64'(out_valid), 64'd1);
    chk("single_ovf", 64'(ovf_o), 64'd0);
    idle(3);

    // Carry out of the low half
    put(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b1);
    step();
    put(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
    step();
    chk("c16_prod_a", 64'(prod_o), 64'h0001_0000);
    in_valid = 1'b0;
    step();
    chk("c16_prod_b", 64'(prod_o), 64'h0000_0000);
    idle(4);

    // Saturation boundary: 256 x -2^31 reaches the minimum exactly
    for (int i = 1; i <= 256; i++) send(32'h8000_0000, 32'h0, 1'(i == 1), 1'(i == 256), 1'b0);
    in_valid = 1'b0;
    wait_out("sat256_valid");
    chk("sat256_acc", 64'(acc_o), 64'h80_0000_0000);
    chk("sat256_ovf", 64'(ovf_o), 64'd0);
    idle(3);
    for (int i = 1; i <= 257; i++) send(32'h8000_0000, 32'h0, 1'(i == 1), 1'(i == 257), 1'b0);
    in_valid = 1'b0;
    wait_out("sat257_valid");
    chk("sat257_acc", 64'(acc_o), 64'h80_0000_0000);
    chk("sat257_ovf", 64'(ovf_o), 64'd1);
    idle(3);

    // Back-to-back with backpressure
    out_ready = 1'b0;
    put(32'd1, 32'd0, 1'b1, 1'b1);
    step();
    put(32'd2, 32'd0, 1'b1, 1'b1);
    step();
    put(32'd3, 32'd0, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_acc", 64'(acc_o), 64'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_acc2", 64'(acc_o), 64'd2);
    chk("bp_valid2", 64'(out_valid), 64'd1);
    step();
    chk("bp_acc3", 64'(acc_o), 64'd3);
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);
    idle(2);

    // Random MAC: 8-product accumulations fed as random carry-save splits
    for (int g = 0; g < 4; g++) begin
      ref_sum = 0;
      target  = n_out + 1;
      for (int j = 0; j < 8; j++) begin
        a  = shortint'($urandom);
        b  = shortint'($urandom);
        pi = int'(a) * int'(b);
        pv = pi;
        r  = $urandom;
        ref_sum = ref_sum + longint'(pi);
        send(r, pv - r, 1'(j == 0), 1'(j == 7), 1'b1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40 && n_out < target; i++) step();
      chk("mac_count", 64'(n_out), 64'(target));
      chk("mac_acc", 64'(last_acc), 64'(ref_sum[39:0]));
    end
    idle(3);

    // Asynchronous reset with a result pending and products in flight
    out_ready = 1'b0;
    put(32'd6, 32'd0, 1'b1, 1'b1);
    step();
    put(32'd1, 32'd0, 1'b1, 1'b0);
    step();
    put(32'd2, 32'd0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("prerst_valid", 64'(out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_acc", 64'(acc_o), 64'd0);
    chk("midrst_prod", 64'(prod_o), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    #4 rst = 1'b0;
    out_ready = 1'b1;
    step();
    put(32'd5, 32'd0, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    wait_out("postrst_valid");
    chk("postrst_acc", 64'(acc_o), 64'd5);
    chk("postrst_ovf", 64'(ovf_o), 64'd0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_acc_stage.md
# booth_acc_stage

Downstream stage of the 16x16 signed radix-4 Booth multiplier. Consumes the Wallace-tree carry-save pair (Sum, Carry, 32 bits each), resolves it with a two-step pipelined carry-propagate add, and accumulates the resulting signed products into a wide, optionally saturating accumulator. Provides valid/ready handshakes on both sides, so the multiplier core can be driven at one product per cycle into a MAC datapath.

## Interface
- ACC_W, 40, accumulator and result width in bits; must be ≥ 33.
- SAT_EN, 1, 1 = saturate accumulator at signed ACC_W limits; 0 = wrap modulo 2^ACC_W.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sum_i/carry_i/first_i/last_i valid.
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready at a rising edge.
- sum_i  in  32  tree Sum vector.
- carry_i  in  32  tree Carry vector (already aligned; no shift applied).
- first_i  in  1  this product starts a new accumulation.
- last_i  in  1  this product ends the accumulation; result is presented.
- out_valid  out  1  acc_o/ovf_o hold a completed accumulation.
- out_ready  in  1  consumer accepts the result.
- acc_o  out  ACC_W  signed accumulation result.
- ovf_o  out  1  sticky: saturation (SAT_EN=1) or signed wrap (SAT_EN=0) occurred in this accumulation.
- prod_o  out  32  last resolved product (debug, from the S2 register).

## Operation
- Global advance enable: en = !(out_valid && !out_ready); in_ready = en (combinational). When en = 0, all pipeline registers, including valid bits, hold.
- S1, on accept: lo = sum_i[15:0] + carry_i[15:0] (17 bits); register lo[15:0], c16 = lo[16], sum_i[31:16], carry_i[31:16], first, last; v1 = 1. When en = 1 with no accept: v1 = 0.
- S2, when v1: hi = sum_hi + carry_hi + c16, kept mod 2^16; product = {hi, lo}, interpreted as signed 32-bit (modulo 2^32, identical to the multiplier's result); register to prod_o; v2 = 1.
- S3, when v2, with p = sign-extend(product) to ACC_W:
  - first = 1: acc = p, ovf = 0.
  - first = 0: t = acc + p, computed at ACC_W+1 bits.
    - SAT_EN = 1: t > 2^(ACC_W-1)-1 clamps to the maximum and sets ovf; t < -2^(ACC_W-1) clamps to the minimum and sets ovf.
    - SAT_EN = 0: acc = t mod 2^ACC_W; ovf is set on signed overflow.
  - ovf is sticky until the next first.
- Result register: when S3 processes last = 1, acc_o and ovf_o load the new acc/ovf value and out_valid = 1.
  - Otherwise out_valid clears on out_valid && out_ready.
  - If both happen in the same cycle, the set wins.
- first and last both set: single-product result equal to sign-extend(product).
- last without a preceding first: accumulation continues from the current acc.
- Products with neither flag: accumulate silently; acc_o is not updated.

## Timing
- Reset values: in_ready = 1 after reset; out_valid = 0, acc_o = 0, ovf_o = 0, prod_o = 0. Internal acc, v1, v2 and the S1 registers are all 0.
- Latency, no stall:
  - input accepted at edge k;
  - prod_o updates at edge k+1;
  - acc_o/out_valid update at edge k+2.
- Throughput: one product per cycle while out_ready is high or no result is pending.
- Stall: whenever out_valid && !out_ready, in_ready = 0 and S1–S3 freeze. No data is lost or duplicated, and out_valid/acc_o stay stable until accepted.
- Reset mid-operation: all in-flight products and the pending result are discarded immediately (asynchronous). First valid accept is possible at the first rising edge after rst deasserts.

## Test plan
- Single product: sum_i=0xFFFFFFF0, carry_i=0x00000001, first=last=1 -> prod_o=0xFFFFFFF1 one edge after accept; two edges after accept, acc_o=0xFFFFFFFFF1 (−15), out_valid=1, ovf_o=0.
- Low-half carry: sum_i=0x0000FFFF, carry_i=0x00000001 -> prod_o=0x00010000 (c16 propagates); sum_i=0xFFFFFFFF, carry_i=0x00000001 -> 0x00000000.
- Saturation, ACC_W=40, SAT_EN=1: 256 products of 0x80000000 (first on #1, last on #256) -> acc_o=0x8000000000, ovf_o=0. The same with 257 products -> acc_o=0x8000000000, ovf_o=1.
- Back-to-back plus backpressure: three first/last transactions of +1, +2, +3 at one per cycle, out_ready=0 for 4 cycles.
  - Required: in_ready=0 while the result is pending; acc_o holds 1.
  - After release, results 1, 2, 3 appear in order with no loss or duplication.
- Multi-product MAC with random A/B over 8-product accumulations: the tree Sum/Carry from the multiplier core feeds the stage, and acc_o is compared against a reference sum of A*B.
- Reset mid-accumulation: after 2 of 4 products, pulse rst asynchronously mid-cycle -> out_valid=0 and acc_o=0 immediately; a following first/last product of 5 yields acc_o=5.
